// File: rtl/pc_cmd_gen.sv
// pc_cmd_gen: multi-channel counting word generator driven by PC commands.
//
// Commands arrive as 32-bit words from a first-word-fall-through write FIFO.
// Each command loads, stops or clears generator channels. Busy channels count
// down (LOAD_DOWN) or up (LOAD_UP). A round-robin arbiter picks one busy channel
// per cycle and writes its current value, tagged with the channel index, to
// the PC read FIFO.
//
// Command word: [31:28] opcode, [27:24] channel, [CNT_W-1:0] count.
//   0x1 LOAD_DOWN  emit count, count-1, ..., 1
//   0x2 LOAD_UP    emit 0, 1, ..., count-1
//   0x3 STOP       idle the addressed channel
//   0x4 STOP_ALL   idle every channel (channel field ignored)
//   Other opcodes, and channel >= N_CH on 0x1..0x3, are consumed and counted
//   in err_cnt (saturating at 255).
//
// Handshakes (valid/ready):
//   command side : the word in cmd_data is valid while !cmd_empty. cmd_rden is a
//                  registered one-cycle pop. The word is applied on the clock
//                  edge that ends the cmd_rden cycle. cmd_rden is never high two
//                  cycles in a row.
//   output side  : out_wren is a write strobe qualified by !out_full in the same
//                  cycle. A word is transferred, and its channel advances, on
//                  every edge where out_wren is high.
//
// Ports:
//   bus_clk    sole clock, rising edge
//   reset      asynchronous, active-high
//   cmd_data   command word (FWFT)
//   cmd_empty  command FIFO empty
//   cmd_rden   command acknowledge/pop
//   out_data   {channel[3:0], zeros, value[CNT_W-1:0]}
//   out_wren   output write strobe
//   out_full   output FIFO full; holds all counters and the arbiter
//   busy       per-channel active flag
//   eof        nothing busy, nothing pending on the command side
//   err_cnt    saturating count of rejected commands
//   state_dbg  per-channel state, 2 bits per channel (channel i at [2i+1:2i])
//
// Optional feature, enabled by defining macro PC_CMD_GEN_ECHO_EN:
//   echo_data/echo_wren copy each acknowledged command word out in its
//   cmd_rden cycle. echo_full withholds cmd_rden.
module pc_cmd_gen #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 24,
    parameter int OUT_W = 32
) (
    input  logic              bus_clk,
    input  logic              reset,
    input  logic [31:0]       cmd_data,
    input  logic              cmd_empty,
    output logic              cmd_rden,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_wren,
    input  logic              out_full,
    output logic [N_CH-1:0]   busy,
    output logic              eof,
    output logic [7:0]        err_cnt,
    output logic [2*N_CH-1:0] state_dbg
`ifdef PC_CMD_GEN_ECHO_EN
    ,
    output logic [31:0]       echo_data,
    output logic              echo_wren,
    input  logic              echo_full
`endif
);

    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DOWN = 2'd1;
    localparam logic [1:0] ST_UP   = 2'd2;

    localparam logic [3:0] OP_LOAD_DOWN = 4'h1;
    localparam logic [3:0] OP_LOAD_UP   = 4'h2;
    localparam logic [3:0] OP_STOP      = 4'h3;
    localparam logic [3:0] OP_STOP_ALL  = 4'h4;

    logic [1:0]       ch_st  [N_CH];
    logic [CNT_W-1:0] ch_cnt [N_CH];
    // Last value of an UP sequence (count-1).
    logic [CNT_W-1:0] ch_lim [N_CH];

    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    rr_wrap;
    logic [PW:0]      rr_inc;

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    logic [3:0]       cmd_op;
    logic [3:0]       cmd_ch;
    logic [CNT_W-1:0] cmd_cnt;
    logic             cmd_ch_ok;
    logic             cmd_is_load;
    logic             cmd_is_stop;
    logic             cmd_valid;
    logic             cmd_reject;
    logic             op_down;
    logic             rden_hold;

    assign cmd_op      = cmd_data[31:28];
    assign cmd_ch      = cmd_data[27:24];
    assign cmd_cnt     = cmd_data[CNT_W-1:0];
    assign cmd_ch_ok   = ({1'b0, cmd_ch} < 5'(N_CH));
    assign cmd_is_load = (cmd_op == OP_LOAD_DOWN) || (cmd_op == OP_LOAD_UP);
    assign cmd_is_stop = (cmd_op == OP_STOP);
    assign op_down     = (cmd_op == OP_LOAD_DOWN);
    assign cmd_valid   = (cmd_op == OP_STOP_ALL) ||
                         ((cmd_is_load || cmd_is_stop) && cmd_ch_ok);
    // The command is applied on the edge that ends the cmd_rden cycle.
    assign cmd_reject  = cmd_rden && !cmd_valid;

    logic [N_CH-1:0] hit_load;
    logic [N_CH-1:0] hit_stop;
    logic [N_CH-1:0] elig;
    logic [N_CH-1:0] adv;

    always_comb begin
        hit_load = '0;
        hit_stop = '0;
        for (int i = 0; i < N_CH; i++) begin
            hit_load[i] = cmd_rden && cmd_is_load && cmd_ch_ok &&
                          (cmd_ch == 4'(i));
            hit_stop[i] = cmd_rden && ((cmd_op == OP_STOP_ALL) ||
                          (cmd_is_stop && cmd_ch_ok && (cmd_ch == 4'(i))));
        end
    end

    // A channel touched by the command being applied sits out this cycle,
    // so a restart never races with the old sequence advancing.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_CH; i++) begin
            elig[i] = busy[i] && !hit_load[i] && !hit_stop[i];
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter: rr_ptr is the first channel to consider.
    // ------------------------------------------------------------------
    logic          gnt_found;
    logic [PW-1:0] gnt_idx;
    logic [PW:0]   scan_ext;
    logic [PW-1:0] scan_idx;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_ext  = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_CH; k++) begin
            scan_ext = {1'b0, rr_ptr} + (PW+1)'(k);
            if (scan_ext >= (PW+1)'(N_CH)) begin
                scan_ext = scan_ext - (PW+1)'(N_CH);
            end
            scan_idx = scan_ext[PW-1:0];
            if (!gnt_found && elig[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    assign out_wren = gnt_found && !out_full;

    always_comb begin
        out_data                 = '0;
        out_data[OUT_W-1 -: 4]   = 4'(gnt_idx);
        out_data[CNT_W-1:0]      = ch_cnt[gnt_idx];
    end

    always_comb begin
        adv = '0;
        for (int i = 0; i < N_CH; i++) begin
            adv[i] = out_wren && (gnt_idx == PW'(i));
        end
    end

    always_comb begin
        rr_inc  = {1'b0, gnt_idx} + (PW+1)'(1);
        rr_wrap = (rr_inc >= (PW+1)'(N_CH)) ? '0 : rr_inc[PW-1:0];
    end

    // ------------------------------------------------------------------
    // Channel state machines
    // ------------------------------------------------------------------
    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                ch_st[i]  <= ST_IDLE;
                ch_cnt[i] <= '0;
                ch_lim[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (hit_load[i]) begin
                    // count==0 is a legal no-op that still aborts the channel.
                    if (cmd_cnt == '0) begin
                        ch_st[i] <= ST_IDLE;
                    end else if (op_down) begin
                        ch_st[i] <= ST_DOWN;
                    end else begin
                        ch_st[i] <= ST_UP;
                    end
                    ch_cnt[i] <= op_down ? cmd_cnt : '0;
                    ch_lim[i] <= cmd_cnt - 1'b1;
                end else if (hit_stop[i]) begin
                    ch_st[i] <= ST_IDLE;
                end else if (adv[i]) begin
                    if (ch_st[i] == ST_DOWN) begin
                        ch_cnt[i] <= ch_cnt[i] - 1'b1;
                        if (ch_cnt[i] == CNT_W'(1)) begin
                            ch_st[i] <= ST_IDLE;
                        end
                    end else begin
                        ch_cnt[i] <= ch_cnt[i] + 1'b1;
                        if (ch_cnt[i] == ch_lim[i]) begin
                            ch_st[i] <= ST_IDLE;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        busy      = '0;
        state_dbg = '0;
        for (int i = 0; i < N_CH; i++) begin
            busy[i]            = (ch_st[i] != ST_IDLE);
            state_dbg[2*i +: 2] = ch_st[i];
        end
    end

    // ------------------------------------------------------------------
    // Arbiter pointer, command acknowledge, error counter
    // ------------------------------------------------------------------
`ifdef PC_CMD_GEN_ECHO_EN
    assign rden_hold = echo_full;
    assign echo_wren = cmd_rden;
    assign echo_data = cmd_data;
`else
    assign rden_hold = 1'b0;
`endif

    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            rr_ptr   <= '0;
            cmd_rden <= 1'b0;
            err_cnt  <= 8'd0;
        end else begin
            if (out_wren) begin
                rr_ptr <= rr_wrap;
            end
            // Forced low after each pop so the FWFT FIFO has a cycle to
            // present its next word.
            cmd_rden <= !cmd_empty && !cmd_rden && !rden_hold;
            if (cmd_reject && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    assign eof = (busy == '0) && cmd_empty && !cmd_rden;

endmodule

// File: tb/tb_pc_cmd_gen.sv
module tb_pc_cmd_gen;

    localparam int N_CH  = 4;
    localparam int CNT_W = 24;
    localparam int OUT_W = 32;

    logic              bus_clk;
    logic              reset;
    logic [31:0]       cmd_data;
    logic              cmd_empty;
    logic              cmd_rden;
    logic [OUT_W-1:0]  out_data;
    logic              out_wren;
    logic              out_full;
    logic [N_CH-1:0]   busy;
    logic              eof;
    logic [7:0]        err_cnt;
    logic [2*N_CH-1:0] state_dbg;
`ifdef PC_CMD_GEN_ECHO_EN
    logic [31:0]       echo_data;
    logic              echo_wren;
    logic              echo_full;
`endif

    pc_cmd_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .OUT_W(OUT_W)) dut (
        .bus_clk   (bus_clk),
        .reset     (reset),
        .cmd_data  (cmd_data),
        .cmd_empty (cmd_empty),
        .cmd_rden  (cmd_rden),
        .out_data  (out_data),
        .out_wren  (out_wren),
        .out_full  (out_full),
        .busy      (busy),
        .eof       (eof),
        .err_cnt   (err_cnt),
        .state_dbg (state_dbg)
`ifdef PC_CMD_GEN_ECHO_EN
        ,
        .echo_data (echo_data),
        .echo_wren (echo_wren),
        .echo_full (echo_full)
`endif
    );

    // ---------------- clock / reset ----------------
    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- command FIFO (FWFT) ----------------
    logic [31:0] cmd_q[$];
    bit          pop_pending = 1'b0;

    always @(posedge bus_clk) begin
        #2;
        if (pop_pending && cmd_q.size() > 0) void'(cmd_q.pop_front());
        cmd_empty = (cmd_q.size() == 0);
        cmd_data  = cmd_empty ? 32'h0 : cmd_q[0];
    end

    // ---------------- behavioural model + compare ----------------
    // Each channel is a queue of the words it still owes.
    logic [31:0]     ch_q [N_CH][$];
    int              m_ptr = 0;
    int              m_err = 0;
    bit              m_rden = 1'b0;
    int              op_i, ch_i, cnt_i, g, jj;
    bit              found, exp_wren, exp_eof, m_hold;
    logic [N_CH-1:0] excl, exp_busy;
    logic [31:0]     exp_data;
    logic [31:0]     got_q[$];
    int              got_cyc[$];
    logic [31:0]     echo_got[$];

    always @(negedge bus_clk) begin
        cyc++;
        if (reset) begin
            for (int c = 0; c < N_CH; c++) ch_q[c].delete();
            m_ptr  = 0;
            m_err  = 0;
            m_rden = 1'b0;
            pop_pending = 1'b0;
            chk("rst_cmd_rden", cmd_rden, 0);
            chk("rst_out_wren", out_wren, 0);
            chk("rst_busy", busy, 0);
            chk("rst_err_cnt", err_cnt, 0);
        end else begin
            op_i  = int'(cmd_data[31:28]);
            ch_i  = int'(cmd_data[27:24]);
            cnt_i = int'(cmd_data[23:0]);
            excl  = '0;
            if (m_rden) begin
                if (op_i == 4) excl = '1;
                else if (op_i >= 1 && op_i <= 3 && ch_i < N_CH) excl[ch_i] = 1'b1;
            end
            found = 1'b0;
            g = 0;
            for (int k = 0; k < N_CH; k++) begin
                jj = (m_ptr + k) % N_CH;
                if (!found && ch_q[jj].size() > 0 && !excl[jj]) begin
                    found = 1'b1;
                    g = jj;
                end
            end
            exp_wren = found && !out_full;
            for (int c = 0; c < N_CH; c++) exp_busy[c] = (ch_q[c].size() > 0);
            exp_eof = (exp_busy == 0) && cmd_empty && !m_rden;

            chk("cyc_cmd_rden", cmd_rden, m_rden);
            chk("cyc_out_wren", out_wren, exp_wren);
            chk("cyc_busy", busy, exp_busy);
            chk("cyc_eof", eof, exp_eof);
            chk("cyc_err_cnt", err_cnt, m_err);
            if (exp_wren) begin
                exp_data = (32'(g) << 28) | ch_q[g][0];
                chk("cyc_out_data", out_data, exp_data);
            end
`ifdef PC_CMD_GEN_ECHO_EN
            chk("cyc_echo_wren", echo_wren, m_rden);
            if (m_rden) chk("cyc_echo_data", echo_data, cmd_data);
            if (echo_wren) echo_got.push_back(echo_data);
`endif
            if (out_wren) begin
                got_q.push_back(out_data);
                got_cyc.push_back(cyc);
            end

            // advance the model across the coming edge
            if (exp_wren) begin
                void'(ch_q[g].pop_front());
                m_ptr = (g + 1) % N_CH;
            end
            if (m_rden) begin
                if ((op_i == 1 || op_i == 2) && ch_i < N_CH) begin
                    ch_q[ch_i].delete();
                    if (op_i == 1) for (int v = cnt_i; v >= 1; v--) ch_q[ch_i].push_back(32'(v));
                    else           for (int v = 0; v < cnt_i; v++) ch_q[ch_i].push_back(32'(v));
                end else if (op_i == 3 && ch_i < N_CH) begin
                    ch_q[ch_i].delete();
                end else if (op_i == 4) begin
                    for (int c = 0; c < N_CH; c++) ch_q[c].delete();
                end else if (m_err < 255) begin
                    m_err = m_err + 1;
                end
            end
            pop_pending = cmd_rden;
            m_hold = 1'b0;
`ifdef PC_CMD_GEN_ECHO_EN
            m_hold = echo_full;
`endif
            m_rden = !cmd_empty && !m_rden && !m_hold;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge bus_clk);
        #1;
    endtask

    task automatic wait_eof(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        cycles(3);
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge bus_clk);
            #1;
            if (eof) seen = 1'b1;
        end
        chk({name, "_eof_timeout"}, seen, 1);
    endtask

    task automatic wait_words(input string name, input int n, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge bus_clk);
            #1;
            if (got_q.size() >= n) seen = 1'b1;
        end
        chk({name, "_words_timeout"}, seen, 1);
    endtask

    logic [31:0] exp_q[$];

    task automatic chk_got(input string name);
        chk({name, "_nwords"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk($sformatf("%s_w%0d", name, i), got_q[i], exp_q[i]);
        end
    endtask

    task automatic clear_got();
        got_q.delete();
        got_cyc.delete();
    endtask

    // ---------------- directed stimulus ----------------
    int n_before;

    initial begin
        reset     = 1'b1;
        out_full  = 1'b0;
        cmd_empty = 1'b1;
        cmd_data  = 32'h0;
`ifdef PC_CMD_GEN_ECHO_EN
        echo_full = 1'b0;
`endif
        cycles(3);
        reset = 1'b0;
        cycles(2);
        @(negedge bus_clk); #1;
        chk("idle_busy", busy, 0);
        chk("idle_eof", eof, 1);
        chk("idle_err", err_cnt, 0);
        chk("idle_wren", out_wren, 0);

        // LOAD_DOWN ch0 count 3
        @(posedge bus_clk); #1;
        clear_got();
        cmd_q.push_back(32'h1000_0003);
        wait_eof("down3", 50);
        exp_q = '{32'h0000_0003, 32'h0000_0002, 32'h0000_0001};
        chk_got("down3");
        if (got_cyc.size() >= 3) begin
            chk("down3_gap01", got_cyc[1] - got_cyc[0], 1);
            chk("down3_gap12", got_cyc[2] - got_cyc[1], 1);
        end
        chk("down3_busy", busy, 0);
        chk("down3_eof", eof, 1);

        // LOAD_UP ch1 count 2 + LOAD_DOWN ch2 count 2, released together
        @(posedge bus_clk); #1;
        clear_got();
        out_full = 1'b1;
        cmd_q.push_back(32'h2100_0002);
        cmd_q.push_back(32'h1200_0002);
        cycles(8);
        chk("rr_loaded_busy", busy, 4'b0110);
        out_full = 1'b0;
        wait_eof("rr", 50);
        exp_q = '{32'h1000_0000, 32'h2000_0002, 32'h1000_0001, 32'h2000_0001};
        chk_got("rr");

        // LOAD_DOWN ch0 count 5, stall 4 cycles after the 2nd word
        @(posedge bus_clk); #1;
        clear_got();
        cmd_q.push_back(32'h1000_0005);
        wait_words("stall", 2, 30);
        @(posedge bus_clk); #1;
        out_full = 1'b1;
        n_before = got_q.size();
        cycles(4);
        chk("stall_no_words", got_q.size(), n_before);
        out_full = 1'b0;
        wait_eof("stall", 50);
        exp_q = '{32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
        chk_got("stall");
        if (got_cyc.size() >= 3) chk("stall_gap", got_cyc[2] - got_cyc[1], 5);

        // undefined opcode, then channel out of range
        @(posedge bus_clk); #1;
        clear_got();
        cmd_q.push_back(32'h7000_0000);
        cmd_q.push_back(32'h1900_0003);
        wait_eof("reject", 50);
        chk("reject_err", err_cnt, 2);
        chk("reject_busy", busy, 0);
        chk("reject_nwords", got_q.size(), 0);

        // count 0 is a no-op
        @(posedge bus_clk); #1;
        clear_got();
        cmd_q.push_back(32'h1300_0000);
        cmd_q.push_back(32'h2300_0000);
        wait_eof("zero", 30);
        chk("zero_nwords", got_q.size(), 0);
        chk("zero_err", err_cnt, 2);

        // STOP one channel mid-sequence
        @(posedge bus_clk); #1;
        cmd_q.push_back(32'h2000_000A);
        cycles(6);
        cmd_q.push_back(32'h3000_0000);
        wait_eof("stop", 40);
        chk("stop_busy", busy, 0);

        // STOP_ALL with a junk channel field
        @(posedge bus_clk); #1;
        cmd_q.push_back(32'h1100_0014);
        cmd_q.push_back(32'h1200_0014);
        cmd_q.push_back(32'h2000_0014);
        cycles(10);
        cmd_q.push_back(32'h4F00_0000);
        wait_eof("stopall", 40);
        chk("stopall_busy", busy, 0);
        chk("stopall_err", err_cnt, 2);

        // restart a busy channel with a new LOAD
        @(posedge bus_clk); #1;
        clear_got();
        cmd_q.push_back(32'h1300_0009);
        cycles(4);
        cmd_q.push_back(32'h2300_0002);
        wait_eof("restart", 40);
        if (got_q.size() >= 2) begin
            chk("restart_last0", got_q[got_q.size()-2], 32'h3000_0000);
            chk("restart_last1", got_q[got_q.size()-1], 32'h3000_0001);
        end else begin
            chk("restart_nwords", got_q.size(), 2);
        end

        // error counter saturation
        @(posedge bus_clk); #1;
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 1) cmd_q.push_back({4'h1, 4'(4 + i % 12), 24'h5});
            else            cmd_q.push_back({4'(5 + i % 11), 28'h0});
        end
        wait_eof("sat", 1000);
        chk("sat_err", err_cnt, 255);
        chk("sat_model_err", m_err, 255);

`ifdef PC_CMD_GEN_ECHO_EN
        // echo path and echo_full back-pressure
        @(posedge bus_clk); #1;
        clear_got();
        echo_got.delete();
        echo_full = 1'b1;
        cmd_q.push_back(32'h1000_0004);
        cycles(5);
        chk("echo_held_q", cmd_q.size(), 1);
        chk("echo_held_n", echo_got.size(), 0);
        echo_full = 1'b0;
        wait_eof("echo", 40);
        chk("echo_n", echo_got.size(), 1);
        if (echo_got.size() >= 1) chk("echo_word", echo_got[0], 32'h1000_0004);
        exp_q = '{32'h4, 32'h3, 32'h2, 32'h1};
        chk_got("echo");
`endif

        // reset in the middle of a long sequence
        @(posedge bus_clk); #1;
        clear_got();
        cmd_q.push_back(32'h1000_0064);
        cycles(10);
        chk("midrst_running", busy, 4'b0001);
        reset = 1'b1;
        n_before = got_q.size();
        cycles(2);
        reset = 1'b0;
        cycles(20);
        chk("midrst_no_words", got_q.size(), n_before);
        chk("midrst_busy", busy, 0);
        chk("midrst_err", err_cnt, 0);
        chk("midrst_wren", out_wren, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pc_cmd_gen.md
PC_CMD_GEN -- requirements
Module: pc_cmd_gen

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent generator channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 24, per-channel counter width (1..24).
REQ-003 SHALL have parameter OUT_W, default 32, output word width, required to satisfy OUT_W >= CNT_W+4.
REQ-004 SHALL have port bus_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cmd_data  input  32  command word from PC write FIFO, first-word-fall-through, valid while !cmd_empty.
REQ-007 SHALL have port cmd_empty  input  1  command FIFO empty.
REQ-008 SHALL have port cmd_rden  output  1  registered one-cycle command acknowledge.
REQ-009 SHALL have port out_data  output  OUT_W  generated word: [OUT_W-1:OUT_W-4] channel index, [CNT_W-1:0] value, remaining bits zero.
REQ-010 SHALL have port out_wren  output  1  write strobe to PC read FIFO.
REQ-011 SHALL have port out_full  input  1  PC read FIFO full.
REQ-012 SHALL have port busy  output  N_CH  per-channel active flag.
REQ-013 SHALL have port eof  output  1  high when busy==0, cmd_empty and cmd_rden low.
REQ-014 SHALL have port err_cnt  output  8  saturating count of rejected commands.

Function
REQ-015 SHALL decode cmd_data as opcode [31:28], channel [27:24], count [CNT_W-1:0]; bits [23:CNT_W] ignored.
REQ-016 SHALL assert cmd_rden for exactly one cycle when cmd_empty is low and cmd_rden was low the previous cycle; the word is applied on that edge, so maximum command rate is one per two cycles.
REQ-017 SHALL, for opcode 0x1 LOAD_DOWN, load the channel with count and emit count, count-1, ..., 1 (count words), then go idle.
REQ-018 SHALL, for opcode 0x2 LOAD_UP, emit 0, 1, ..., count-1 (count words), then go idle.
REQ-019 SHALL, for opcode 0x3 STOP, idle the addressed channel immediately; opcode 0x4 STOP_ALL idles every channel.
REQ-020 SHALL treat count==0 on LOAD_DOWN/LOAD_UP as a valid no-op leaving the channel idle.
REQ-021 SHALL reject (consume, no effect, err_cnt+1, saturating at 255) any undefined opcode or channel >= N_CH; opcode 0x4 ignores the channel field.
REQ-022 SHALL let a LOAD to a busy channel abort its sequence and restart with the new one.
REQ-023 SHALL per channel hold states IDLE, DOWN, UP; IDLE->DOWN/UP on LOAD with count!=0; DOWN->IDLE after emitting 1; UP->IDLE after emitting count-1; any->IDLE on STOP/STOP_ALL/reset.
REQ-024 SHALL arbitrate busy channels round-robin, starting at the channel after the last granted one, granting at most one word per cycle.
REQ-025 SHALL drive out_wren combinationally as (any eligible channel) && !out_full, with out_data from the granted channel in the same cycle; the granted channel advances on that edge.
REQ-026 SHALL, when out_full is high, emit nothing and hold all counters and the round-robin pointer.
REQ-027 SHALL exclude from arbitration, in the cycle a command is applied, the channel(s) that command addresses.
REQ-028 SHALL drive busy[i] high exactly while channel i is in DOWN or UP.

Reset
REQ-029 SHALL, on reset, asynchronously set all channels IDLE, counters 0, round-robin pointer to channel 0, err_cnt 0, cmd_rden 0; out_wren is then 0.
REQ-030 SHALL, on reset asserted mid-sequence, discard the sequence with no further out_wren until a new LOAD.

Configuration
REQ-031 SHALL, with macro PC_CMD_GEN_ECHO_EN defined, add ports echo_data (output, 32), echo_wren (output, 1), echo_full (input, 1), and write each acknowledged command word to echo_data with echo_wren high in the cycle cmd_rden is high; cmd_rden is also withheld while echo_full is high.
REQ-032 SHALL, without PC_CMD_GEN_ECHO_EN, omit the echo ports and logic entirely.

Verification
REQ-033 SHALL cover: LOAD_DOWN ch0 count 3, out_full low -> out_data 0x00000003, 0x00000002, 0x00000001 on consecutive cycles, then busy[0] falls, eof rises.
REQ-034 SHALL cover: LOAD_UP ch1 count 2 and LOAD_DOWN ch2 count 2 -> words interleave round-robin: 0x10000000, 0x20000002, 0x10000001, 0x20000001.
REQ-035 SHALL cover: LOAD_DOWN ch0 count 5 with out_full held high for 4 cycles after the 2nd word -> no out_wren during the stall, then 3, 2, 1 resume, no word lost or duplicated.
REQ-036 SHALL cover: opcode 0x7, then channel 9 with N_CH=4 -> both consumed, err_cnt=2, busy stays 0.
REQ-037 SHALL cover: reset pulsed mid LOAD_DOWN count 100 -> out_wren low from reset onward, busy=0, err_cnt=0.
REQ-038 SHALL cover, with PC_CMD_GEN_ECHO_EN: command 0x10000004 -> echo_data 0x10000004 with echo_wren in the cmd_rden cycle; echo_full high -> cmd_rden withheld.
